// File: rtl/intra_sad_argmin.sv
// Streaming SAD engine: accumulates |residual| per candidate mode over one block,
// then scans the per-mode SADs sequentially to pick the cheapest enabled mode.
module intra_sad_argmin #(
  parameter int NMODES  = 8,
  parameter int SAMPLES = 16,
  parameter int LANES   = 4,
  parameter int RW      = 9,
  parameter int BEATS   = SAMPLES / LANES,
  parameter int SW      = RW + $clog2(SAMPLES),
  parameter int MW      = (NMODES > 2) ? $clog2(NMODES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NMODES*LANES*RW-1:0]  in_res,
  input  logic [NMODES-1:0]           mode_mask,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NMODES*SW-1:0]        sads,
  output logic [MW-1:0]               best_mode,
  output logic [SW-1:0]               best_sad,
  output logic                        none_valid
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     beat_cnt;
  logic [MW-1:0]     scan_idx;
  logic [NMODES-1:0] mask_q;
  logic [SW-1:0]     acc [NMODES];
  logic [SW-1:0]     beat_sum [NMODES];
  logic [SW-1:0]     best_sad_q;
  logic [MW-1:0]     best_mode_q;
  logic              found_q;
  logic              scan_take;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);

  // Per-mode sum of lane magnitudes for the current beat.
  // NOTE: every always_comb output gets a default before any conditional use,
  // so no latch can be inferred.
  always_comb begin
    for (int m = 0; m < NMODES; m++) begin
      beat_sum[m] = '0;
      for (int l = 0; l < LANES; l++) begin
        logic [RW-1:0] r;
        logic [RW-1:0] a;
        r = in_res[(m*LANES+l)*RW +: RW];
        // -2^(RW-1) negates to itself, which read unsigned is exactly 2^(RW-1).
        a = r[RW-1] ? (~r + RW'(1)) : r;
        beat_sum[m] = beat_sum[m] + SW'(a);
      end
    end
  end

  assign scan_take = mask_q[scan_idx] && (!found_q || (acc[scan_idx] < best_sad_q));

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ACCUM;
      beat_cnt    <= '0;
      scan_idx    <= '0;
      mask_q      <= '0;
      best_sad_q  <= '0;
      best_mode_q <= '0;
      found_q     <= 1'b0;
      // NOTE: the accumulator array is reset because it drives sads directly
      // and sads must read zero out of reset.
      for (int m = 0; m < NMODES; m++) acc[m] <= '0;
    end else if (abort) begin
      state    <= ST_ACCUM;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            for (int m = 0; m < NMODES; m++)
              acc[m] <= ((beat_cnt == '0) ? '0 : acc[m]) + beat_sum[m];
            if (beat_cnt == '0) mask_q <= mode_mask;
            if (beat_cnt == CW'(BEATS-1)) begin
              beat_cnt    <= '0;
              state       <= ST_SCAN;
              scan_idx    <= '0;
              best_sad_q  <= '1;
              best_mode_q <= '0;
              found_q     <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_SCAN: begin
          if (scan_take) begin
            best_sad_q  <= acc[scan_idx];
            best_mode_q <= scan_idx;
            found_q     <= 1'b1;
          end
          if (scan_idx == MW'(NMODES-1)) state <= ST_DONE;
          else scan_idx <= scan_idx + MW'(1);
        end
        ST_DONE: begin
          if (out_ready) state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  for (genvar g = 0; g < NMODES; g++) begin : g_sads
    assign sads[g*SW +: SW] = acc[g];
  end

  assign best_mode  = best_mode_q;
  assign best_sad   = best_sad_q;
  assign none_valid = (state == ST_DONE) && !found_q;

endmodule

// File: tb/tb_intra_sad_argmin.sv
// Directed and randomized bench for intra_sad_argmin, checked against a block-level
// reference model (per-mode SAD sums and minimum search over enabled modes).
module tb_intra_sad_argmin;

  localparam int NMODES  = 8;
  localparam int SAMPLES = 16;
  localparam int LANES   = 4;
  localparam int RW      = 9;
  localparam int BEATS   = SAMPLES / LANES;
  localparam int SW      = RW + $clog2(SAMPLES);
  localparam int MW      = $clog2(NMODES);

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [NMODES*LANES*RW-1:0] in_res;
  logic [NMODES-1:0]          mode_mask;
  logic                       abort;
  logic                       out_valid;
  logic                       out_ready;
  logic [NMODES*SW-1:0]       sads;
  logic [MW-1:0]              best_mode;
  logic [SW-1:0]              best_sad;
  logic                       none_valid;

  intra_sad_argmin dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .mode_mask(mode_mask), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .sads(sads),
    .best_mode(best_mode), .best_sad(best_sad), .none_valid(none_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int res [NMODES][SAMPLES];
  int exp_sad [NMODES];
  int exp_best;
  int exp_bsad;
  int exp_none;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int v);
    for (int m = 0; m < NMODES; m++)
      for (int s = 0; s < SAMPLES; s++) res[m][s] = v;
  endtask

  task automatic fill_random();
    for (int m = 0; m < NMODES; m++)
      for (int s = 0; s < SAMPLES; s++) res[m][s] = int'($urandom_range(0, 511)) - 256;
  endtask

  // Reference: SAD is the plain sum of magnitudes; the winner is the smallest
  // SAD among enabled modes, lowest index among equals.
  task automatic model(input logic [NMODES-1:0] mask);
    int mn;
    for (int m = 0; m < NMODES; m++) begin
      exp_sad[m] = 0;
      for (int s = 0; s < SAMPLES; s++)
        exp_sad[m] += (res[m][s] < 0) ? -res[m][s] : res[m][s];
    end
    mn = -1;
    for (int m = 0; m < NMODES; m++)
      if (mask[m] && (mn < 0 || exp_sad[m] < mn)) mn = exp_sad[m];
    exp_none = (mn < 0);
    exp_best = 0;
    exp_bsad = (1 << SW) - 1;
    if (!exp_none) begin
      exp_bsad = mn;
      for (int m = NMODES - 1; m >= 0; m--)
        if (mask[m] && exp_sad[m] == mn) exp_best = m;
    end
  endtask

  task automatic pack_beat(input int b);
    for (int m = 0; m < NMODES; m++)
      for (int l = 0; l < LANES; l++)
        in_res[(m*LANES+l)*RW +: RW] = RW'(res[m][b*LANES+l]);
  endtask

  task automatic send_beats(input int first, input int n, input logic [NMODES-1:0] mask);
    for (int b = first; b < first + n; b++) begin
      pack_beat(b);
      mode_mask = mask;
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    for (int m = 0; m < NMODES; m++)
      check($sformatf("%s.sad%0d", tag, m), 64'(sads[m*SW +: SW]), 64'(exp_sad[m]));
    check({tag, ".best_mode"}, 64'(best_mode), 64'(exp_best));
    check({tag, ".best_sad"}, 64'(best_sad), 64'(exp_bsad));
    check({tag, ".none_valid"}, 64'(none_valid), 64'(exp_none));
  endtask

  // Sends a block, measures the latency to out_valid, checks, then handshakes.
  task automatic run_block(input string tag, input logic [NMODES-1:0] mask, input bit early);
    int cyc;
    model(mask);
    out_ready = early;
    send_beats(0, BEATS, mask);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(NMODES));
    check_result(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".released"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; in_res = '0; mode_mask = '0;
    abort = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.sads", 64'(sads), 64'd0);
    check("rst.best", 64'({best_mode, best_sad, none_valid}), 64'd0);

    // Asynchronous reset in the middle of a block.
    fill_const(3);
    send_beats(0, 2, 8'hFF);
    #2 reset = 1'b1;
    #1;
    check("async_rst.sads", 64'(sads), 64'd0);
    check("async_rst.best", 64'({best_mode, best_sad, none_valid, out_valid}), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_block("plus3", 8'hFF, 1'b0);

    // Mode m residuals all -(m+1).
    for (int m = 0; m < NMODES; m++)
      for (int s = 0; s < SAMPLES; s++) res[m][s] = -(m + 1);
    run_block("ramp", 8'hFF, 1'b0);

    // Modes 2 and 5 alternate +-1; tie rule and masking.
    for (int m = 0; m < NMODES; m++)
      for (int s = 0; s < SAMPLES; s++)
        res[m][s] = (m == 2 || m == 5) ? ((s % 2) ? -1 : 1) : 5;
    run_block("tie_masked", 8'hFB, 1'b0);
    run_block("tie_full", 8'hFF, 1'b1);

    // Most-negative residual everywhere, then no modes enabled.
    fill_const(-256);
    run_block("minneg", 8'hFF, 1'b0);
    run_block("nomask", 8'h00, 1'b0);

    // Result stall with in_valid held high, then back-to-back next block.
    fill_random();
    model(8'hFF);
    send_beats(0, BEATS, 8'hFF);
    for (int c = 0; c < NMODES; c++) tick();
    check_result("stall0");
    in_valid = 1'b1;
    pack_beat(0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("stall.in_ready%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("stall.hold%0d", c),
            64'({out_valid, best_mode, best_sad}), 64'({1'b1, MW'(exp_best), SW'(exp_bsad)}));
    end
    check("stall.sad7", 64'(sads[7*SW +: SW]), 64'(exp_sad[7]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs.in_ready", 64'(in_ready), 64'd1);
    fill_random();
    run_block("b2b", 8'h5A, 1'b0);

    // Abort with a simultaneous beat; the block must vanish.
    fill_const(1);
    send_beats(0, 2, 8'hFF);
    pack_beat(2);
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort.no_out", 64'(seen), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    run_block("after_abort", 8'hFF, 1'b0);

    // Randomized blocks with random masks and alternating early out_ready.
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_block($sformatf("rnd%0d", k), (k == 3) ? 8'h00 : 8'($urandom_range(0, 255)), k[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
